// File: rtl/loopback_writer_if.sv
// FIFO dequeue port plus the C1 write request/response channel seen by the loopback writer.
// The master modport is the writer; the slave modport is the FIFO/host side.
interface loopback_writer_if #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 42
);
   logic [DATA_WIDTH-1:0] fifo_deq_data;
   logic                  fifo_empty;
   logic                  fifo_deq_en;
   logic                  tx_wr_valid;
   logic [ADDR_WIDTH-1:0] tx_wr_addr;
   logic [DATA_WIDTH-1:0] tx_wr_data;
   logic [15:0]           tx_wr_mdata;
   logic                  tx_almost_full;
   logic                  rx_wr_rsp_valid;

   modport master (
      input  fifo_deq_data,
      input  fifo_empty,
      input  tx_almost_full,
      input  rx_wr_rsp_valid,
      output fifo_deq_en,
      output tx_wr_valid,
      output tx_wr_addr,
      output tx_wr_data,
      output tx_wr_mdata
   );

   modport slave (
      output fifo_deq_data,
      output fifo_empty,
      output tx_almost_full,
      output rx_wr_rsp_valid,
      input  fifo_deq_en,
      input  tx_wr_valid,
      input  tx_wr_addr,
      input  tx_wr_data,
      input  tx_wr_mdata
   );
endinterface

// File: rtl/loopback_writer.sv
// Loopback write engine: drains FIFO lines into consecutive cache-line writes,
// throttled by host almost-full and an outstanding-write limit.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | out of reset, waiting for start
// S_RUN   | issuing one write per FIFO line until length lines are sent
// S_DRAIN | all lines sent, waiting for the remaining write responses
// S_DONE  | every line written and acknowledged; counters held
module loopback_writer #(
   parameter int DATA_WIDTH      = 512,
   parameter int ADDR_WIDTH      = 42,
   parameter int LEN_WIDTH       = 32,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] wr_base_addr,
   input  logic [LEN_WIDTH-1:0]  num_lines,
   loopback_writer_if.master     bus,
   output logic                  busy,
   output logic                  done,
   output logic [LEN_WIDTH-1:0]  lines_sent,
   output logic [LEN_WIDTH-1:0]  lines_acked
);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [OUT_W-1:0]      outstanding;
   logic                  issue;
   logic                  rsp_cnt;
   logic                  start_ok;

   logic                  tx_valid_q;
   logic [ADDR_WIDTH-1:0] tx_addr_q;
   logic [DATA_WIDTH-1:0] tx_data_q;
   logic [15:0]           tx_mdata_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt = (num_lines != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (lines_sent == len_q) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((lines_acked == len_q) && (outstanding == '0)) begin
               state_nxt = S_DONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy            = (state == S_RUN) || (state == S_DRAIN);
      done            = (state == S_DONE);
      start_ok        = start && ((state == S_IDLE) || (state == S_DONE));
      issue           = (state == S_RUN) && !bus.fifo_empty && !bus.tx_almost_full &&
                        (outstanding < OUT_MAX) && (lines_sent < len_q);
      // Responses only count while a transfer is live and something is in flight.
      rsp_cnt         = busy && bus.rx_wr_rsp_valid && (outstanding != '0);
      bus.fifo_deq_en = issue;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q      <= '0;
         len_q       <= '0;
         lines_sent  <= '0;
         lines_acked <= '0;
         outstanding <= '0;
      end else if (start_ok) begin
         base_q      <= wr_base_addr;
         len_q       <= num_lines;
         lines_sent  <= '0;
         lines_acked <= '0;
         outstanding <= '0;
      end else begin
         if (issue) begin
            lines_sent <= lines_sent + LEN_WIDTH'(1);
         end
         if (rsp_cnt) begin
            lines_acked <= lines_acked + LEN_WIDTH'(1);
         end
         case ({issue, rsp_cnt})
            2'b10:   outstanding <= outstanding + OUT_W'(1);
            2'b01:   outstanding <= outstanding - OUT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Request register: address and mdata use the pre-increment line index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_valid_q <= 1'b0;
         tx_addr_q  <= '0;
         tx_data_q  <= '0;
         tx_mdata_q <= '0;
      end else begin
         tx_valid_q <= issue;
         if (issue) begin
            tx_addr_q  <= base_q + ADDR_WIDTH'(lines_sent);
            tx_data_q  <= bus.fifo_deq_data;
            tx_mdata_q <= lines_sent[15:0];
         end
      end
   end

   assign bus.tx_wr_valid = tx_valid_q;
   assign bus.tx_wr_addr  = tx_addr_q;
   assign bus.tx_wr_data  = tx_data_q;
   assign bus.tx_wr_mdata = tx_mdata_q;
endmodule

// File: tb/tb_loopback_writer.sv
// Directed bench for loopback_writer: FIFO and response models, request monitor,
// and immediate-assertion checks against hand-computed values.
module tb_loopback_writer;
   localparam int DW = 512;
   localparam int AW = 42;
   localparam int LW = 32;
   localparam int MO = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] wr_base_addr = '0;
   logic [LW-1:0] num_lines = '0;
   logic          busy;
   logic          done;
   logic [LW-1:0] lines_sent;
   logic [LW-1:0] lines_acked;

   loopback_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   loopback_writer #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .wr_base_addr(wr_base_addr), .num_lines(num_lines),
      .bus(bus),
      .busy(busy), .done(done),
      .lines_sent(lines_sent), .lines_acked(lines_acked)
   );

   always #5 clk = ~clk;

   // show-ahead FIFO model
   logic [DW-1:0] fmem [0:63];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   assign bus.fifo_empty    = (rd_ptr == wr_ptr);
   assign bus.fifo_deq_data = fmem[rd_ptr[5:0]];
   always @(posedge clk) if (bus.fifo_deq_en) rd_ptr <= rd_ptr + 1;

   // response model: auto response two cycles after each request, plus manual pulses
   logic [1:0] rsp_pipe = 2'b00;
   logic       auto_rsp = 1'b0;
   logic       man_rsp = 1'b0;
   logic       af = 1'b0;
   always @(posedge clk) rsp_pipe <= {rsp_pipe[0], bus.tx_wr_valid & auto_rsp};
   assign bus.rx_wr_rsp_valid = rsp_pipe[1] | man_rsp;
   assign bus.tx_almost_full  = af;

   // request monitor
   int            cyc = 0;
   logic [AW-1:0] req_addr  [0:127];
   logic [DW-1:0] req_data  [0:127];
   logic [15:0]   req_mdata [0:127];
   int            req_cyc   [0:127];
   int            req_cnt = 0;
   int            busy_cnt = 0;
   int            deq_cnt = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (bus.tx_wr_valid) begin
         req_addr[req_cnt[6:0]]  <= bus.tx_wr_addr;
         req_data[req_cnt[6:0]]  <= bus.tx_wr_data;
         req_mdata[req_cnt[6:0]] <= bus.tx_wr_mdata;
         req_cyc[req_cnt[6:0]]   <= cyc;
         req_cnt                 <= req_cnt + 1;
      end
      if (busy) busy_cnt <= busy_cnt + 1;
      if (bus.fifo_deq_en) deq_cnt <= deq_cnt + 1;
   end

   int n_pass = 0;
   int n_checks = 0;
   int nid = 0;

   function automatic logic [6:0] idx(int k);
      return 7'(k);
   endfunction

   function automatic logic [DW-1:0] pat(int i);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(i);
      return {16{w}};
   endfunction

   task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(int n);
      for (int i = 0; i < n; i++) begin
         fmem[wr_ptr[5:0]] = pat(nid);
         wr_ptr++;
         nid++;
      end
   endtask

   task automatic start_run(logic [AW-1:0] base, logic [LW-1:0] n);
      start        = 1'b1;
      wr_base_addr = base;
      num_lines    = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(string tag, int budget);
      for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
      chk(tag, done, 1);
   endtask

   task automatic chk_seq(string tag, int r0, int id0, logic [AW-1:0] base, int n);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (req_data[idx(r0 + i)] !== pat(id0 + i)) ok = 1'b0;
         if (req_addr[idx(r0 + i)] !== base + AW'(i)) ok = 1'b0;
         if (req_mdata[idx(r0 + i)] !== 16'(i)) ok = 1'b0;
      end
      chk(tag, ok, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, d0, b0, id0, a, in_win, at_resume;

      // reset state
      @(negedge clk);
      chk("rst_deq_en", bus.fifo_deq_en, 0);
      chk("rst_tx_valid", bus.tx_wr_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sent", lines_sent, 0);
      chk("rst_acked", lines_acked, 0);
      chk("rst_addr", bus.tx_wr_addr, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // zero-length transfer
      push(1);
      r0 = req_cnt; d0 = deq_cnt; b0 = busy_cnt;
      start_run(AW'(42'h123), 0);
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      repeat (3) @(negedge clk);
      chk("zero_no_deq", deq_cnt - d0, 0);
      chk("zero_no_req", req_cnt - r0, 0);
      chk("zero_no_busy", busy_cnt - b0, 0);
      chk("zero_done_hold", done, 1);
      wr_ptr = rd_ptr;

      // basic 4-line transfer with auto responses
      auto_rsp = 1'b1;
      r0 = req_cnt; id0 = nid;
      push(4);
      start_run(AW'(42'h1000), 4);
      chk("b_busy", busy, 1);
      wait_done("b_done", 60);
      chk("b_nreq", req_cnt - r0, 4);
      chk_seq("b_seq", r0, id0, AW'(42'h1000), 4);
      chk("b_addr3", req_addr[idx(r0 + 3)], 42'h1003);
      chk("b_consec", req_cyc[idx(r0 + 3)] - req_cyc[idx(r0)], 3);
      chk("b_sent", lines_sent, 4);
      chk("b_acked", lines_acked, 4);
      chk("b_fifo_drained", bus.fifo_empty, 1);

      // outstanding limit
      auto_rsp = 1'b0;
      r0 = req_cnt; id0 = nid;
      push(20);
      start_run(AW'(42'h2000), 20);
      repeat (40) @(negedge clk);
      chk("c_stall16", req_cnt - r0, 16);
      chk("c_sent16", lines_sent, 16);
      chk("c_busy", busy, 1);
      man_rsp = 1'b1;
      @(negedge clk);
      man_rsp = 1'b0;
      repeat (10) @(negedge clk);
      chk("c_one_more", req_cnt - r0, 17);
      chk("c_acked1", lines_acked, 1);
      man_rsp = 1'b1;
      wait_done("c_done", 100);
      man_rsp = 1'b0;
      chk("c_nreq", req_cnt - r0, 20);
      chk("c_acked", lines_acked, 20);
      chk_seq("c_seq", r0, id0, AW'(42'h2000), 20);

      // almost-full window mid-transfer
      auto_rsp = 1'b1;
      r0 = req_cnt; id0 = nid;
      push(12);
      start_run(AW'(42'h4000), 12);
      repeat (3) @(negedge clk);
      af = 1'b1;
      a = cyc;
      repeat (5) @(negedge clk);
      af = 1'b0;
      wait_done("d_done", 100);
      in_win = 0; at_resume = 0;
      for (int i = 0; i < 12; i++) begin
         if (req_cyc[idx(r0 + i)] >= a + 1 && req_cyc[idx(r0 + i)] <= a + 5) in_win++;
         if (req_cyc[idx(r0 + i)] == a + 6) at_resume++;
      end
      chk("d_none_in_window", in_win, 0);
      chk("d_resume", at_resume, 1);
      chk("d_nreq", req_cnt - r0, 12);
      chk_seq("d_seq", r0, id0, AW'(42'h4000), 12);

      // address wrap
      r0 = req_cnt; id0 = nid;
      push(2);
      start_run(AW'(42'h3FF_FFFF_FFFF), 2);
      wait_done("e_done", 50);
      chk("e_nreq", req_cnt - r0, 2);
      chk("e_addr0", req_addr[idx(r0)], 42'h3FF_FFFF_FFFF);
      chk("e_addr1", req_addr[idx(r0 + 1)], 42'h0);
      chk("e_mdata1", req_mdata[idx(r0 + 1)], 1);

      // reset mid-transfer, stray responses, then a fresh 1-line run
      auto_rsp = 1'b0;
      push(8);
      start_run(AW'(42'h5000), 8);
      for (int i = 0; i < 20 && lines_sent != 3; i++) @(negedge clk);
      chk("f_reached3", lines_sent, 3);
      reset_n = 1'b0;
      #1;
      chk("f_rst_sent", lines_sent, 0);
      chk("f_rst_busy", busy, 0);
      chk("f_rst_valid", bus.tx_wr_valid, 0);
      @(negedge clk);
      reset_n = 1'b1;
      wr_ptr = rd_ptr;
      @(negedge clk);
      man_rsp = 1'b1;
      @(negedge clk);
      man_rsp = 1'b0;
      @(negedge clk);
      man_rsp = 1'b1;
      @(negedge clk);
      man_rsp = 1'b0;
      @(negedge clk);
      chk("f_stray_acked", lines_acked, 0);
      chk("f_stray_done", done, 0);
      chk("f_stray_busy", busy, 0);
      r0 = req_cnt; id0 = nid;
      push(1);
      auto_rsp = 1'b1;
      start_run(AW'(42'h6000), 1);
      wait_done("f_done", 50);
      chk("f_nreq", req_cnt - r0, 1);
      chk("f_addr", req_addr[idx(r0)], 42'h6000);
      chk("f_data", req_data[idx(r0)], pat(id0));
      chk("f_acked", lines_acked, 1);
      chk("f_sent", lines_sent, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
